// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types_pkg
//  Purpose  : Basic CPU-wide data types shared by the memory subsystem.
//  Contents : word_t - 32-bit machine word.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/diaosi_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : diaosi_types_pkg
//  Purpose  : Types for the cache/RAM arbiter.
//  Contents : ramstate_t  - RAM port status (FREE, BUSY, ACCESS, ERROR)
//             arb_state_t - arbiter FSM state (IDLE, IACC, DACC)
//  Revision : 1.0 - initial release
// ============================================================================
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

endpackage : diaosi_types_pkg
`default_nettype wire

// File: rtl/cache_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : cache_arb_if
//  Purpose  : Bundles the icache, dcache and RAM-port signals of the arbiter.
//  Modports : master - arbiter view (cache requests/RAM status in,
//                      waits/loads/RAM request out)
//             slave  - environment view (caches + RAM), directions reversed
//  Revision : 1.0 - initial release
// ============================================================================
interface cache_arb_if;
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;

    // icache side
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    // dcache side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    // RAM port
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    ramstate_t ramstate;
    word_t     ramload;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface : cache_arb_if
`default_nettype wire

// File: rtl/arb_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : arb_perf_cnt
//  Purpose  : Free-running performance counters for the cache arbiter.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             i_icomp / i_dcomp   - one-cycle icache / dcache completion
//             i_stall             - a non-granted cache is requesting
//             o_icnt / o_dcnt     - completion counts
//             o_stallcnt          - contention-cycle count
//  Notes    : All counters wrap modulo 2^32.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_perf_cnt
    import cpu_types_pkg::*;
(
    input  wire   clk,
    input  wire   rst,
    input  wire   i_icomp,
    input  wire   i_dcomp,
    input  wire   i_stall,
    output word_t o_icnt,
    output word_t o_dcnt,
    output word_t o_stallcnt
);

    word_t r_icnt;
    word_t r_dcnt;
    word_t r_stallcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_icnt     <= '0;
            r_dcnt     <= '0;
            r_stallcnt <= '0;
        end else begin
            if (i_icomp) r_icnt     <= r_icnt + 32'd1;
            if (i_dcomp) r_dcnt     <= r_dcnt + 32'd1;
            if (i_stall) r_stallcnt <= r_stallcnt + 32'd1;
        end
    end

    assign o_icnt     = r_icnt;
    assign o_dcnt     = r_dcnt;
    assign o_stallcnt = r_stallcnt;

endmodule : arb_perf_cnt
`default_nettype wire

// File: rtl/cache_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cache_arb
//  Purpose  : Arbitrates one RAM port between an icache and a dcache.
//             dcache has priority, except that after a dcache access to the
//             upper word of a two-word block (daddr[2]=1) with the icache
//             waiting, the icache is granted next (ifair).
//  Ports    : CLK       - clock (rising edge)
//             RST       - synchronous active-high reset
//             bus       - cache_arb_if.master (cache requests, waits, loads,
//                         RAM port)
//             icnt, dcnt, stallcnt - performance counters (ARB_PERF_EN only)
//  Config   : ARB_PERF_EN - when defined, adds the counter ports and the
//             arb_perf_cnt instance.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_arb
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
(
    input  wire           CLK,
    input  wire           RST,
    cache_arb_if.master   bus
`ifdef ARB_PERF_EN
    ,
    output word_t         icnt,
    output word_t         dcnt,
    output word_t         stallcnt
`endif
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_ifair;
    logic       w_ifair_next;

    logic       w_dreq;
    logic       w_done;
    logic       w_icomp;
    logic       w_dcomp;

    assign w_dreq  = bus.dREN | bus.dWEN;
    // A cycle with RST high never completes, so a reset aborts cleanly.
    assign w_done  = (bus.ramstate == ACCESS) & ~RST;
    // Completion also needs the request still present: a dropped request
    // simply falls back to IDLE without a pulse.
    assign w_icomp = (r_state == IACC) & bus.iREN & w_done;
    assign w_dcomp = (r_state == DACC) & w_dreq   & w_done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_ifair <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ifair <= w_ifair_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ifair_next = r_ifair;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        case (r_state)
            IDLE: begin
                if (r_ifair && bus.iREN) begin
                    w_next       = IACC;
                    w_ifair_next = 1'b0;
                end else if (w_dreq) begin
                    w_next = DACC;
                end else if (bus.iREN) begin
                    w_next       = IACC;
                    w_ifair_next = 1'b0;
                end
            end

            IACC: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (w_icomp) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                    w_next    = IDLE;
                end else if (!bus.iREN) begin
                    w_next = IDLE;
                end
            end

            DACC: begin
                bus.ramREN   = bus.dREN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (w_dcomp) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                    w_next    = IDLE;
                    // Second word of a block done while icache waits:
                    // let the icache in before the next dcache access.
                    if (bus.daddr[2] && bus.iREN) begin
                        w_ifair_next = 1'b1;
                    end
                end else if (!w_dreq) begin
                    w_next = IDLE;
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef ARB_PERF_EN
    // Contention: the cache that does not own the RAM port is requesting.
    logic w_stall;
    assign w_stall = ((r_state == IACC) & w_dreq) |
                     ((r_state == DACC) & bus.iREN);

    arb_perf_cnt u_perf (
        .clk        (CLK),
        .rst        (RST),
        .i_icomp    (w_icomp),
        .i_dcomp    (w_dcomp),
        .i_stall    (w_stall),
        .o_icnt     (icnt),
        .o_dcnt     (dcnt),
        .o_stallcnt (stallcnt)
    );
`endif

endmodule : cache_arb
`default_nettype wire

// File: tb/tb_cache_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_arb
//  Purpose  : Self-checking bench for cache_arb. Expected completions are
//             queued when a request is issued and popped when a wait drops.
//             A small RAM model returns an address-derived word.
//  Config   : ARB_PERF_EN - also checks icnt/dcnt/stallcnt.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_arb;
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    cache_arb_if bus ();

`ifdef ARB_PERF_EN
    word_t icnt;
    word_t dcnt;
    word_t stallcnt;
`endif

    cache_arb dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus)
`ifdef ARB_PERF_EN
        ,
        .icnt     (icnt),
        .dcnt     (dcnt),
        .stallcnt (stallcnt)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic word_t mem_f(input word_t a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    always_comb bus.ramload = mem_f(bus.ramaddr);

    typedef struct packed {
        logic  is_d;
        word_t data;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_ipush = 0;
    int   n_dpush = 0;
    int   exp_stall = 0;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push_i(input word_t a);
        sb.push_back({1'b0, mem_f(a)});
        n_ipush++;
    endtask

    task automatic push_d(input word_t a);
        sb.push_back({1'b1, mem_f(a)});
        n_dpush++;
    endtask

    // Per-cycle monitor: pops the scoreboard on any completion.
    task automatic mon();
        exp_t       e;
        logic [1:0] w;
        w = {bus.iwait, bus.dwait};
        if (w != 2'b11) begin
            if (sb.size() == 0) begin
                chk("unexpected_completion_waits", {30'b0, w}, 32'd3);
            end else begin
                e = sb.pop_front();
                chk("comp_waits", {30'b0, w}, e.is_d ? 32'd2 : 32'd1);
                chk("comp_load", e.is_d ? bus.dload : bus.iload, e.data);
                chk("comp_other_load", e.is_d ? bus.iload : bus.dload, 32'd0);
            end
        end else begin
            chk("loads_zero", bus.iload | bus.dload, 32'd0);
        end
    endtask

    task automatic samp();
        @(negedge CLK);
        mon();
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST          = 1'b1;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramstate = FREE;

        // ---- reset values ----
        adv();
        samp();
        chk("rst_iwait",    bus.iwait,    32'd1);
        chk("rst_dwait",    bus.dwait,    32'd1);
        chk("rst_ramREN",   bus.ramREN,   32'd0);
        chk("rst_ramWEN",   bus.ramWEN,   32'd0);
        chk("rst_ramaddr",  bus.ramaddr,  32'd0);
        chk("rst_ramstore", bus.ramstore, 32'd0);
        adv();
        RST = 1'b0;

        // ---- reset during a dcache access ----
        bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = BUSY;
        samp(); chk("mr_idle_ramREN", bus.ramREN, 32'd0); adv();
        samp(); chk("mr_dacc_ramREN", bus.ramREN, 32'd1);
        chk("mr_dacc_ramaddr", bus.ramaddr, 32'h300); adv();
        RST = 1'b1;
        samp(); chk("mr_rstcyc_dwait", bus.dwait, 32'd1); adv();
        RST = 1'b0; bus.dREN = 1'b0;
        samp();
        chk("mr_after_dwait",   bus.dwait,   32'd1);
        chk("mr_after_ramREN",  bus.ramREN,  32'd0);
        chk("mr_after_ramaddr", bus.ramaddr, 32'd0);
        adv();

        // ---- single icache read, immediate ACCESS ----
        bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = ACCESS; push_i(32'h40);
        samp(); chk("a_c1_iwait", bus.iwait, 32'd1); chk("a_c1_ramREN", bus.ramREN, 32'd0); adv();
        samp();
        chk("a_c2_iwait",   bus.iwait,   32'd0);
        chk("a_c2_iload",   bus.iload,   32'hDEAD_BEEF);
        chk("a_c2_dwait",   bus.dwait,   32'd1);
        chk("a_c2_ramaddr", bus.ramaddr, 32'h40);
        chk("a_c2_ramWEN",  bus.ramWEN,  32'd0);
        adv();
        bus.iREN = 1'b0;
        samp(); chk("a_c3_iwait", bus.iwait, 32'd1); adv();

        // ---- dcache write, BUSY x3 then ACCESS ----
        bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h1234_5678;
        bus.ramstate = BUSY; push_d(32'h200);
        samp(); chk("w_c1_ramWEN", bus.ramWEN, 32'd0); adv();
        for (int k = 2; k <= 5; k++) begin
            bus.ramstate = (k == 5) ? ACCESS : BUSY;
            samp();
            chk("w_ramWEN",   bus.ramWEN,   32'd1);
            chk("w_ramREN",   bus.ramREN,   32'd0);
            chk("w_ramstore", bus.ramstore, 32'h1234_5678);
            chk("w_ramaddr",  bus.ramaddr,  32'h200);
            chk("w_dwait",    bus.dwait,    (k == 5) ? 32'd0 : 32'd1);
            adv();
        end
        bus.dWEN = 1'b0; bus.ramstate = FREE;
        samp(); chk("w_c6_ramWEN", bus.ramWEN, 32'd0); chk("w_c6_dwait", bus.dwait, 32'd1); adv();

        // ---- ERROR x2 then ACCESS ----
        bus.dREN = 1'b1; bus.daddr = 32'h208; bus.ramstate = ERROR; push_d(32'h208);
        samp(); adv();
        for (int k = 2; k <= 4; k++) begin
            bus.ramstate = (k == 4) ? ACCESS : ERROR;
            samp();
            chk("e_dwait", bus.dwait, (k == 4) ? 32'd0 : 32'd1);
            adv();
        end
        bus.dREN = 1'b0; bus.ramstate = FREE;
        samp(); adv();

        // ---- request dropped mid-access ----
        bus.dREN = 1'b1; bus.daddr = 32'h400; bus.ramstate = BUSY;
        samp(); adv();
        samp(); chk("drop_dacc_ramREN", bus.ramREN, 32'd1); adv();
        bus.dREN = 1'b0; bus.ramstate = ACCESS;
        samp(); chk("drop_dwait", bus.dwait, 32'd1); chk("drop_dload", bus.dload, 32'd0); adv();
        bus.iREN = 1'b1; bus.iaddr = 32'h44; push_i(32'h44);
        samp(); chk("drop_idle_iwait", bus.iwait, 32'd1); adv();
        samp(); chk("drop_iacc_iwait", bus.iwait, 32'd0); adv();
        bus.iREN = 1'b0;
        samp(); adv();

        // ---- simultaneous requests: dcache first ----
        bus.ramstate = ACCESS;
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h100;
        push_d(32'h100); push_i(32'h80);
        samp(); chk("s_c1_iwait", bus.iwait, 32'd1); chk("s_c1_dwait", bus.dwait, 32'd1); adv();
        samp(); chk("s_c2_dwait", bus.dwait, 32'd0); chk("s_c2_iwait", bus.iwait, 32'd1); adv();
        bus.dREN = 1'b0;
        samp(); chk("s_c3_iwait", bus.iwait, 32'd1); adv();
        samp(); chk("s_c4_iwait", bus.iwait, 32'd0); adv();
        bus.iREN = 1'b0;
        samp(); adv();

        // ---- block transfer then fairness ----
        bus.iREN = 1'b1; bus.iaddr = 32'hC0; bus.dREN = 1'b1; bus.daddr = 32'h100;
        push_d(32'h100);
        samp(); adv();
        samp(); chk("f_d100_dwait", bus.dwait, 32'd0); adv();
        bus.daddr = 32'h104; push_d(32'h104);
        samp(); chk("f_idle1_dwait", bus.dwait, 32'd1); adv();
        samp(); chk("f_d104_dwait", bus.dwait, 32'd0); chk("f_d104_iwait", bus.iwait, 32'd1); adv();
        bus.daddr = 32'h108; push_i(32'hC0);
        samp(); chk("f_idle2_iwait", bus.iwait, 32'd1); adv();
        samp();
        chk("f_iacc_iwait",   bus.iwait,   32'd0);
        chk("f_iacc_dwait",   bus.dwait,   32'd1);
        chk("f_iacc_ramaddr", bus.ramaddr, 32'hC0);
        adv();
        bus.iREN = 1'b0; push_d(32'h108);
        samp(); adv();
        samp(); chk("f_d108_dwait", bus.dwait, 32'd0); adv();
        bus.dREN = 1'b0;
        samp(); adv();
        chk("sb_drained_main", sb.size(), 32'd0);

        // ---- counter run: 3 icache + 2 dcache completions ----
        RST = 1'b1; adv(); RST = 1'b0;
        n_ipush = 0; n_dpush = 0; exp_stall = 0;
        bus.ramstate = ACCESS;
        bus.iREN = 1'b1; bus.iaddr = 32'h10; bus.dREN = 1'b1; bus.daddr = 32'h20;
        push_d(32'h20); push_i(32'h10);
        samp(); adv();
        samp(); adv(); exp_stall++;          // DACC done, icache waiting
        bus.dREN = 1'b0;
        samp(); adv();
        samp(); adv();                       // IACC done, no dcache request
        bus.iREN = 1'b0;
        samp(); adv();

        bus.iREN = 1'b1; bus.iaddr = 32'h14; bus.dREN = 1'b1; bus.daddr = 32'h28;
        push_d(32'h28); push_i(32'h14);
        samp(); adv();
        bus.ramstate = BUSY;
        samp(); adv(); exp_stall++;          // DACC busy, icache waiting
        bus.ramstate = ACCESS;
        samp(); adv(); exp_stall++;          // DACC done, icache waiting
        bus.dREN = 1'b0;
        samp(); adv();
        samp(); adv();
        bus.iREN = 1'b0;
        samp(); adv();

        bus.iREN = 1'b1; bus.iaddr = 32'h18; push_i(32'h18);
        samp(); adv();
        samp(); adv();
        bus.iREN = 1'b0;
        samp();
        chk("sb_drained_perf", sb.size(), 32'd0);
`ifdef ARB_PERF_EN
        chk("perf_icnt",     icnt,     n_ipush);
        chk("perf_dcnt",     dcnt,     n_dpush);
        chk("perf_icnt_3",   icnt,     32'd3);
        chk("perf_dcnt_2",   dcnt,     32'd2);
        chk("perf_stallcnt", stallcnt, exp_stall);
`endif
        adv();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_cache_arb
`default_nettype wire
